// File: rtl/mem_io_responder.sv
// Byte-wide RAM plus a small I/O window (UART TX/RX FIFOs, program-end flag)
// answering the CPU memory controller with fixed one-cycle read latency.
module mem_io_responder #(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        mem_wr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_wr_data_i,
  output logic [7:0]  ram_out,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_overflow,
  output logic        tx_overflow,
  output logic        program_end_o
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;
  localparam logic [TCW-1:0] TX_THRESH = TCW'(TX_DEPTH - FULL_MARGIN);

  logic [7:0] mem_q [2**RAM_AW];
  logic [7:0] mem_rd_q;
  logic [7:0] io_rd_q, io_rd_d;
  logic       sel_ram_q;

  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TPW-1:0] tx_wptr_q, tx_rptr_q;
  logic [TCW-1:0] tx_count_q, tx_count_d;
  logic           tx_full, tx_push, tx_pop;
  logic           full_q, tx_ovf_q;

  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RPW-1:0] rx_wptr_q, rx_rptr_q;
  logic [RCW-1:0] rx_count_q, rx_count_d;
  logic           rx_full, rx_nonempty, rx_push, rx_pop;
  logic           rx_ovf_q, pend_q;

  logic              io, io_off0, io_off4, bus_wr, bus_rd;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr;

  assign io          = (mem_addr_i[17:16] == 2'b11);
  assign io_off0     = io && (mem_addr_i[15:0] == 16'h0000);
  assign io_off4     = io && (mem_addr_i[15:0] == 16'h0004);
  assign ram_idx     = mem_addr_i[RAM_AW-1:0];
  assign unused_addr = ^mem_addr_i[31:18];
  assign bus_wr      = rdy_in && mem_wr_i;
  assign bus_rd      = rdy_in && !mem_wr_i;

  // RAM: write port and registered read; contents are never reset
  always_ff @(posedge clk_in) begin
    if (bus_wr && !io) mem_q[ram_idx] <= mem_wr_data_i;
    if (bus_rd && !io) mem_rd_q <= mem_q[ram_idx];
  end

  always_comb begin
    io_rd_d = 8'h00;
    if (io_off0 && rx_nonempty) io_rd_d = rx_mem_q[rx_rptr_q];
    else if (io_off4)           io_rd_d = {7'b0, rx_nonempty};
  end

  // ram_out selects between the RAM read register and the I/O read register;
  // both hold across write cycles and stalls
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_ram_q <= 1'b0;
      io_rd_q   <= 8'h00;
    end else if (bus_rd) begin
      sel_ram_q <= !io;
      if (io) io_rd_q <= io_rd_d;
    end
  end

  assign ram_out = sel_ram_q ? mem_rd_q : io_rd_q;

  // TX FIFO: bus pushes, UART drains regardless of rdy_in
  assign tx_full = (tx_count_q == TCW'(TX_DEPTH));
  assign tx_push = bus_wr && io_off0 && !tx_full;
  assign tx_pop  = (tx_count_q != '0) && tx_ready;

  always_comb begin
    tx_count_d = tx_count_q;
    if (tx_push && !tx_pop)      tx_count_d = tx_count_q + 1'b1;
    else if (!tx_push && tx_pop) tx_count_d = tx_count_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= mem_wr_data_i;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
      full_q     <= 1'b0;
      tx_ovf_q   <= 1'b0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      tx_count_q <= tx_count_d;
      full_q     <= (tx_count_d >= TX_THRESH);
      if (bus_wr && io_off0 && tx_full) tx_ovf_q <= 1'b1;
    end
  end

  assign tx_valid       = (tx_count_q != '0);
  assign tx_data        = tx_valid ? tx_mem_q[tx_rptr_q] : 8'h00;
  assign io_buffer_full = full_q;
  assign tx_overflow    = tx_ovf_q;

  // RX FIFO: UART pushes regardless of rdy_in, bus reads of offset 0 pop
  assign rx_full     = (rx_count_q == RCW'(RX_DEPTH));
  assign rx_nonempty = (rx_count_q != '0);
  assign rx_push     = rx_valid && !rx_full;
  assign rx_pop      = bus_rd && io_off0 && rx_nonempty;

  always_comb begin
    rx_count_d = rx_count_q;
    if (rx_push && !rx_pop)      rx_count_d = rx_count_q + 1'b1;
    else if (!rx_push && rx_pop) rx_count_d = rx_count_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      rx_ovf_q   <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      rx_count_q <= rx_count_d;
      if (rx_valid && rx_full) rx_ovf_q <= 1'b1;
      if (bus_wr && io_off4)   pend_q   <= 1'b1;
    end
  end

  assign rx_overflow   = rx_ovf_q;
  assign program_end_o = pend_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM path, TX/RX FIFOs, flags, stall, reset.
module tb_mem_io_responder;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, mem_wr_i, tx_ready, rx_valid;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_wr_data_i, rx_data;
  logic [7:0]  ram_out, tx_data;
  logic        io_buffer_full, tx_valid, rx_overflow, tx_overflow, program_end_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [31:0] IO_DATA = 32'h0003_0000;
  localparam logic [31:0] IO_END  = 32'h0003_0004;
  localparam logic [31:0] IO_NONE = 32'h0003_0008;

  mem_io_responder dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_wr_i      (mem_wr_i),
    .mem_addr_i    (mem_addr_i),
    .mem_wr_data_i (mem_wr_data_i),
    .ram_out       (ram_out),
    .io_buffer_full(io_buffer_full),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_overflow   (rx_overflow),
    .tx_overflow   (tx_overflow),
    .program_end_o (program_end_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    mem_wr_i      = 1'b0;
    mem_addr_i    = IO_NONE;
    mem_wr_data_i = 8'h00;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
    mem_wr_i = 1'b1; mem_addr_i = a; mem_wr_data_i = d;
    tick();
    idle();
  endtask

  task automatic bus_read(input logic [31:0] a);
    mem_wr_i = 1'b0; mem_addr_i = a;
    tick();
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle();
    tick(); tick();
    total_cnt++; if (ram_out !== 8'h00) $display("FAIL reset_ram_out got=%h exp=00", ram_out); else pass_cnt++;
    total_cnt++; if (io_buffer_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", io_buffer_full); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); else pass_cnt++;
    total_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", tx_data); else pass_cnt++;
    total_cnt++; if ({rx_overflow, tx_overflow, program_end_o} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {rx_overflow, tx_overflow, program_end_o}); else pass_cnt++;
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_ram_roundtrip();
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus_write(32'h10, 8'hA5);
    bus_read(32'h10);
    total_cnt++; if (ram_out !== 8'hA5) $display("FAIL ram_rt got=%h exp=a5", ram_out); else pass_cnt++;
    for (int i = 0; i < 4; i++) bus_write(32'h10 + i, exp_b[i]);
    for (int i = 0; i < 4; i++) begin
      bus_read(32'h10 + i);
      total_cnt++; if (ram_out !== exp_b[i]) $display("FAIL ram_seq%0d got=%h exp=%h", i, ram_out, exp_b[i]); else pass_cnt++;
    end
    bus_write(32'h14, 8'h99);
    total_cnt++; if (ram_out !== 8'h44) $display("FAIL ram_hold_on_write got=%h exp=44", ram_out); else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_tx_fill();
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus_write(IO_DATA, 8'(i));
    total_cnt++; if (io_buffer_full !== 1'b0) $display("FAIL tx_full_at5 got=%b exp=0", io_buffer_full); else pass_cnt++;
    bus_write(IO_DATA, 8'h06);
    total_cnt++; if (io_buffer_full !== 1'b1) $display("FAIL tx_full_at6 got=%b exp=1", io_buffer_full); else pass_cnt++;
    total_cnt++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) $display("FAIL tx_head got=%b/%h exp=1/01", tx_valid, tx_data); else pass_cnt++;
    bus_write(IO_DATA, 8'h07);
    bus_write(IO_DATA, 8'h08);
    total_cnt++; if (tx_overflow !== 1'b0) $display("FAIL tx_ovf_at8 got=%b exp=0", tx_overflow); else pass_cnt++;
    bus_write(IO_DATA, 8'h09);
    total_cnt++; if (tx_overflow !== 1'b1) $display("FAIL tx_ovf_at9 got=%b exp=1", tx_overflow); else pass_cnt++;
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      total_cnt++; if (tx_data !== 8'(k)) $display("FAIL tx_drain%0d got=%h exp=%h", k, tx_data, 8'(k)); else pass_cnt++;
      tick();
      total_cnt++; if (io_buffer_full !== (k <= 2)) $display("FAIL tx_full_drain%0d got=%b exp=%b", k, io_buffer_full, (k <= 2)); else pass_cnt++;
    end
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL tx_empty got=%b exp=0", tx_valid); else pass_cnt++;
    tx_ready = 1'b0;
  endtask

  task automatic test_rx_pop();
    rx_valid = 1'b1; rx_data = 8'h41; tick();
    rx_data = 8'h42; tick();
    rx_valid = 1'b0;
    bus_read(IO_END);
    total_cnt++; if (ram_out !== 8'h01) $display("FAIL rx_status got=%h exp=01", ram_out); else pass_cnt++;
    bus_read(IO_DATA);
    total_cnt++; if (ram_out !== 8'h41) $display("FAIL rx_pop1 got=%h exp=41", ram_out); else pass_cnt++;
    bus_read(IO_DATA);
    total_cnt++; if (ram_out !== 8'h42) $display("FAIL rx_pop2 got=%h exp=42", ram_out); else pass_cnt++;
    bus_read(IO_DATA);
    total_cnt++; if (ram_out !== 8'h00) $display("FAIL rx_pop_empty got=%h exp=00", ram_out); else pass_cnt++;
    bus_read(IO_END);
    total_cnt++; if (ram_out !== 8'h00) $display("FAIL rx_status_empty got=%h exp=00", ram_out); else pass_cnt++;
    total_cnt++; if (rx_overflow !== 1'b0) $display("FAIL rx_ovf_early got=%b exp=0", rx_overflow); else pass_cnt++;
    idle();
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_tx [3] = '{8'hA2, 8'hA3, 8'hA4};
    tx_ready = 1'b0;
    bus_write(IO_DATA, 8'hA1);
    bus_write(IO_DATA, 8'hA2);
    bus_write(IO_DATA, 8'hA3);
    tx_ready = 1'b1;
    bus_write(IO_DATA, 8'hA4);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (tx_valid !== 1'b1 || tx_data !== exp_tx[i])
        $display("FAIL tx_pushpop%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_tx[i]); else pass_cnt++;
      tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    end
    total_cnt++; if (tx_valid !== 1'b0) $display("FAIL tx_pushpop_count got=%b exp=0", tx_valid); else pass_cnt++;
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h50 + 8'(i);
      tick();
    end
    rx_data = 8'h99;
    tick();
    rx_valid = 1'b0;
    total_cnt++; if (rx_overflow !== 1'b1) $display("FAIL rx_ovf got=%b exp=1", rx_overflow); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      bus_read(IO_DATA);
      total_cnt++; if (ram_out !== 8'h50 + 8'(i)) $display("FAIL rx_full_pop%0d got=%h exp=%h", i, ram_out, 8'h50 + 8'(i)); else pass_cnt++;
    end
    bus_read(IO_DATA);
    total_cnt++; if (ram_out !== 8'h00) $display("FAIL rx_after_full got=%h exp=00", ram_out); else pass_cnt++;
    idle();
  endtask

  task automatic test_program_end_stall();
    bus_write(IO_END, 8'h00);
    total_cnt++; if (program_end_o !== 1'b1) $display("FAIL pend_set got=%b exp=1", program_end_o); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (program_end_o !== 1'b1) $display("FAIL pend_sticky got=%b exp=1", program_end_o); else pass_cnt++;
    bus_write(32'h20, 8'h5A);
    rdy_in = 1'b0;
    bus_write(32'h20, 8'hC3);
    rdy_in = 1'b1;
    bus_read(32'h20);
    total_cnt++; if (ram_out !== 8'h5A) $display("FAIL stall_no_write got=%h exp=5a", ram_out); else pass_cnt++;
    rdy_in = 1'b0;
    bus_read(32'h10);
    total_cnt++; if (ram_out !== 8'h5A) $display("FAIL stall_hold got=%h exp=5a", ram_out); else pass_cnt++;
    rdy_in = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    bus_write(IO_DATA, 8'h71);
    bus_write(IO_DATA, 8'h72);
    bus_write(IO_DATA, 8'h73);
    total_cnt++; if (tx_valid !== 1'b1) $display("FAIL pre_reset_tx_valid got=%b exp=1", tx_valid); else pass_cnt++;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    total_cnt++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL rst_mid_tx got=%b/%h exp=0/00", tx_valid, tx_data); else pass_cnt++;
    total_cnt++; if ({rx_overflow, tx_overflow, program_end_o, io_buffer_full} !== 4'b0000)
      $display("FAIL rst_mid_flags got=%b exp=0000", {rx_overflow, tx_overflow, program_end_o, io_buffer_full}); else pass_cnt++;
    total_cnt++; if (ram_out !== 8'h00) $display("FAIL rst_mid_ram_out got=%h exp=00", ram_out); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_ram_roundtrip();
    test_tx_fill();
    test_rx_pop();
    test_simultaneous();
    test_program_end_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the byte-serial bus driven by the CPU memory controller. It holds the byte-wide program/data RAM and decodes the I/O window (`addr[17:16]==2'b11`). The window contains a TX FIFO toward the UART, an RX FIFO from the UART, and a program-end register. It returns read bytes with fixed one-cycle latency and raises `io_buffer_full` so the controller throttles I/O writes.

## Interface
Parameters:
- `RAM_AW`, 17, RAM byte-address width; RAM depth is 2^RAM_AW bytes.
- `TX_DEPTH`, 8, TX FIFO entries; power of two, at least 4.
- `RX_DEPTH`, 8, RX FIFO entries; power of two.
- `FULL_MARGIN`, 2, free TX entries still reserved when `io_buffer_full` asserts; covers writes already committed by the controller.

Ports:
- `clk_in`  in  1  clock; all logic on the rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `rdy_in`  in  1  bus enable; when low, bus-side state freezes.
- `mem_wr_i`  in  1  1 = write, 0 = read; sampled every cycle.
- `mem_addr_i`  in  32  byte address.
- `mem_wr_data_i`  in  8  write byte.
- `ram_out`  out  8  read byte; feeds the controller's `ram_in`.
- `io_buffer_full`  out  1  TX FIFO nearly full.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_data`  out  8  TX FIFO head byte.
- `tx_ready`  in  1  UART consumes the head byte when `tx_valid && tx_ready`.
- `rx_valid`  in  1  UART offers byte `rx_data`.
- `rx_data`  in  8  received byte.
- `rx_overflow`  out  1  sticky; an RX byte was dropped.
- `tx_overflow`  out  1  sticky; a TX write was dropped.
- `program_end_o`  out  1  sticky; program signalled completion.

## Operation
- **Decode:** `io = (mem_addr_i[17:16]==2'b11)`. Otherwise `ram_idx = mem_addr_i[RAM_AW-1:0]`.
- **RAM write** (`mem_wr_i=1`, `!io`): `mem[ram_idx] <= mem_wr_data_i`.
- **RAM read:** every cycle with `mem_wr_i=0`, `!io`: `ram_out <= mem[ram_idx]`.
  - Same-address write and read cannot occur in one cycle (single port).
  - During a write cycle, `ram_out` holds.
- **IO offset 0x0 (addr 0x30000):**
  - Write pushes the byte to TX. If TX is full, the byte is dropped and `tx_overflow` is set.
  - Read pops RX: `ram_out <= rx_head`. If RX is empty, `ram_out <= 8'h00` and nothing is popped.
  - Each cycle the address is presented counts as one access.
- **IO offset 0x4 (addr 0x30004):**
  - Write sets `program_end_o` (any data value).
  - Read returns `{7'b0, rx_nonempty}`.
- **Other IO offsets:** writes are ignored; reads return 8'h00.
- **TX FIFO:** circular buffer with read and write pointers wrapping at `TX_DEPTH`, plus a count register.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop is allowed only when non-empty.
- **RX FIFO:** same structure. A push when full is dropped and sets `rx_overflow`. Push and pop in the same cycle are both honoured.
- **Full flag:** `io_buffer_full = (tx_count >= TX_DEPTH - FULL_MARGIN)`, registered from next-state count.
- **`rdy_in` low:**
  - No RAM write, no FIFO push/pop from the bus, `ram_out` holds.
  - UART-side TX drain and RX push continue.

## Timing
- Reset values:
  - `ram_out` = 0, `io_buffer_full` = 0, `tx_valid` = 0, `tx_data` = 0.
  - Both overflow flags = 0, `program_end_o` = 0.
  - FIFO pointers and counts = 0.
  - RAM contents are not reset.
- Read latency is exactly 1: an address presented in cycle N gives `ram_out` valid in cycle N+1. It holds until the next read cycle.
- Write takes effect at the edge ending cycle N. A read of the same address in N+1 returns the new data in N+2.
- `tx_valid` and `tx_data` reflect the FIFO state after the edge, with no combinational path from bus inputs.
- `io_buffer_full` updates on the same edge as the count change that crosses the threshold.
- Reset mid-transfer: FIFOs empty immediately and in-flight bytes are lost. Sticky flags clear only on reset.

## Test plan
- **RAM round trip:** write 0xA5 to 0x00010, then read 0x00010 -> `ram_out`=0xA5 one cycle after the read address. A 4-byte sequential read of 0x00010..13 after writing 11,22,33,44 returns the bytes in order.
- **TX fill:** `tx_ready`=0, 6 writes to 0x30000 (depth 8, margin 2) -> `io_buffer_full`=1 after the 6th edge.
  - Writes 7 and 8 are accepted; the 9th sets `tx_overflow`.
  - Raising `tx_ready` drains bytes in order and `io_buffer_full` drops at count 5.
- **RX pop:** push 0x41 and 0x42 via `rx_valid`, then read 0x30000 twice -> 0x41, then 0x42. A third read returns 0x00. Reading 0x30004 before the pops returns 0x01.
- **Simultaneous events:** TX push and pop in the same cycle at count 3 -> count stays 3 and order is preserved. RX push while full -> `rx_overflow`=1 and existing data is intact.
- **Program end and stall:** write 0x30004 -> `program_end_o`=1 next cycle and stays high.
  - With `rdy_in`=0, a write to RAM 0x20 is not performed; a later read returns the old value.
  - Reset asserted with 3 TX bytes queued -> `tx_valid`=0 and all flags 0 after the edge.
